// File: rtl/activation_writer.sv
// Activation-stage sink: writes masked rows to output BRAM at base + k*stride.
// Ports: clk/resetn, start+config in, in_data stream in, bram_* out, busy/done/overflow.
module activation_writer #(
  parameter int MAT_MUL_SIZE = 4,
  parameter int DWIDTH       = 8,
  parameter int AWIDTH       = 10,
  parameter int MASK_WIDTH   = MAT_MUL_SIZE
) (
  input  logic                           clk,
  input  logic                           resetn,
  input  logic                           start,
  input  logic [AWIDTH-1:0]              base_addr,
  input  logic [AWIDTH-1:0]              addr_stride,
  input  logic [AWIDTH-1:0]              num_rows,
  input  logic [MASK_WIDTH-1:0]          validity_mask,
  input  logic [MAT_MUL_SIZE*DWIDTH-1:0] in_data,
  input  logic                           in_data_available,
  output logic [AWIDTH-1:0]              bram_addr,
  output logic [MAT_MUL_SIZE*DWIDTH-1:0] bram_wdata,
  output logic [MAT_MUL_SIZE-1:0]        bram_we,
  output logic                           busy,
  output logic                           done,
  output logic                           overflow
);

  typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

  state_t state, state_nxt;

  logic [AWIDTH-1:0]              cur_addr;
  logic [AWIDTH-1:0]              stride;
  logic [AWIDTH-1:0]              rows_left;
  logic [MASK_WIDTH-1:0]          mask;
  logic [MAT_MUL_SIZE*DWIDTH-1:0] masked;
  logic                           start_ok;
  logic                           accept;
  logic                           drop;

  // start is ignored while a run is in progress
  assign start_ok = start && (state != WRITE);
  assign accept   = in_data_available && (state == WRITE);
  assign drop     = in_data_available && (state != WRITE);

  assign busy = (state == WRITE);
  assign done = (state == DONE);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE, DONE: begin
        if (start) begin
          state_nxt = (num_rows == '0) ? DONE : WRITE;
        end
      end
      WRITE: begin
        if (accept && rows_left == AWIDTH'(1)) begin
          state_nxt = DONE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    masked = '0;
    for (int i = 0; i < MAT_MUL_SIZE; i++) begin
      if (mask[i]) begin
        masked[(i+1)*DWIDTH-1 -: DWIDTH] =
          in_data[(i+1)*DWIDTH-1 -: DWIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cur_addr   <= '0;
      stride     <= '0;
      rows_left  <= '0;
      mask       <= '0;
      bram_addr  <= '0;
      bram_wdata <= '0;
      bram_we    <= '0;
      overflow   <= 1'b0;
    end else begin
      bram_we <= '0;
      if (start_ok) begin
        cur_addr  <= base_addr;
        stride    <= addr_stride;
        rows_left <= num_rows;
        mask      <= validity_mask;
      end else if (accept) begin
        bram_addr  <= cur_addr;
        bram_wdata <= masked;
        bram_we    <= mask;
        cur_addr   <= cur_addr + stride;
        rows_left  <= rows_left - AWIDTH'(1);
      end
      // a dropped row beats the clear from a same-cycle start
      if (drop)          overflow <= 1'b1;
      else if (start_ok) overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_activation_writer.sv
// Directed bench for activation_writer.
// Each task drives one scenario and checks outputs 1 time unit after the edge.
module tb_activation_writer;

  logic        clk;
  logic        resetn;
  logic        start;
  logic [9:0]  base_addr;
  logic [9:0]  addr_stride;
  logic [9:0]  num_rows;
  logic [3:0]  validity_mask;
  logic [31:0] in_data;
  logic        in_data_available;
  logic [9:0]  bram_addr;
  logic [31:0] bram_wdata;
  logic [3:0]  bram_we;
  logic        busy;
  logic        done;
  logic        overflow;

  int errors = 0;
  int checks = 0;

  activation_writer dut (
    .clk(clk),
    .resetn(resetn),
    .start(start),
    .base_addr(base_addr),
    .addr_stride(addr_stride),
    .num_rows(num_rows),
    .validity_mask(validity_mask),
    .in_data(in_data),
    .in_data_available(in_data_available),
    .bram_addr(bram_addr),
    .bram_wdata(bram_wdata),
    .bram_we(bram_we),
    .busy(busy),
    .done(done),
    .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    #3;
    resetn = 1'b1;
    tick();
  endtask

  task automatic go(input logic [9:0] b, input logic [9:0] s,
                    input logic [9:0] n, input logic [3:0] m);
    base_addr     = b;
    addr_stride   = s;
    num_rows      = n;
    validity_mask = m;
    start         = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    logic [49:0] got;
    got = {bram_addr, bram_wdata, bram_we, busy, done, overflow};
    checks++;
    if (got !== 50'd0) begin
      errors++;
      $display("FAIL reset_state got=%h exp=0", got);
    end
  endtask

  task automatic test_basic();
    logic [31:0] rows [4];
    rows[0] = 32'h11223344;
    rows[1] = 32'h55667788;
    rows[2] = 32'h99AABBCC;
    rows[3] = 32'hDEADBEEF;
    go(10'h010, 10'd1, 10'd4, 4'b1111);
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL basic_busy got=%b%b exp=10", busy, done);
    end
    for (int i = 0; i < 4; i++) begin
      in_data = rows[i];
      in_data_available = 1'b1;
      tick();
      checks++;
      if (bram_addr !== 10'h010 + 10'(i) || bram_wdata !== rows[i] ||
          bram_we !== 4'b1111) begin
        errors++;
        $display("FAIL basic_row%0d got=%h/%h/%b exp=%h/%h/1111", i,
                 bram_addr, bram_wdata, bram_we, 10'h010 + 10'(i), rows[i]);
      end
      checks++;
      if (done !== (i == 3) || busy !== (i != 3)) begin
        errors++;
        $display("FAIL basic_status%0d got busy=%b done=%b", i, busy, done);
      end
    end
    in_data_available = 1'b0;
    tick();
    checks++;
    if (bram_we !== 4'b0 || busy !== 1'b0 || done !== 1'b1) begin
      errors++;
      $display("FAIL basic_after got we=%b busy=%b done=%b exp 0000/0/1",
               bram_we, busy, done);
    end
  endtask

  task automatic test_mask_stride();
    go(10'h000, 10'd4, 10'd3, 4'b0101);
    for (int i = 0; i < 3; i++) begin
      in_data = 32'hAABBCCDD;
      in_data_available = 1'b1;
      tick();
      checks++;
      if (bram_addr !== 10'(4 * i) || bram_wdata !== 32'h00BB00DD ||
          bram_we !== 4'b0101) begin
        errors++;
        $display("FAIL mask_row%0d got=%h/%h/%b exp=%h/00bb00dd/0101", i,
                 bram_addr, bram_wdata, bram_we, 10'(4 * i));
      end
    end
    in_data_available = 1'b0;
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL mask_done got=%b exp=1", done);
    end
  endtask

  task automatic test_gaps_wrap();
    logic [9:0] exp_a [3];
    exp_a[0] = 10'h3FE;
    exp_a[1] = 10'h3FF;
    exp_a[2] = 10'h000;
    go(10'h3FE, 10'd1, 10'd3, 4'b1111);
    for (int i = 0; i < 3; i++) begin
      in_data = 32'hC0DE0000 + 32'(i);
      in_data_available = 1'b1;
      tick();
      checks++;
      if (bram_addr !== exp_a[i] || bram_we !== 4'b1111 ||
          done !== (i == 2)) begin
        errors++;
        $display("FAIL gap_row%0d got=%h/%b done=%b exp=%h/1111", i,
                 bram_addr, bram_we, done, exp_a[i]);
      end
      in_data_available = 1'b0;
      tick();
      checks++;
      if (bram_we !== 4'b0 || done !== (i == 2)) begin
        errors++;
        $display("FAIL gap_idle%0d got we=%b done=%b", i, bram_we, done);
      end
    end
  endtask

  task automatic test_overflow();
    do_reset();
    in_data = 32'h12345678;
    in_data_available = 1'b1;
    tick();
    in_data_available = 1'b0;
    checks++;
    if (overflow !== 1'b1 || bram_we !== 4'b0) begin
      errors++;
      $display("FAIL ovf_idle got ovf=%b we=%b exp 1/0000", overflow, bram_we);
    end
    go(10'h040, 10'd1, 10'd1, 4'b1111);
    checks++;
    if (overflow !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL ovf_clear got ovf=%b busy=%b exp 0/1", overflow, busy);
    end
    in_data_available = 1'b1;
    tick();
    checks++;
    if (done !== 1'b1 || bram_we !== 4'b1111 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL ovf_run got done=%b we=%b ovf=%b", done, bram_we, overflow);
    end
    tick();
    in_data_available = 1'b0;
    checks++;
    if (overflow !== 1'b1 || bram_we !== 4'b0) begin
      errors++;
      $display("FAIL ovf_done got ovf=%b we=%b exp 1/0000", overflow, bram_we);
    end
    in_data_available = 1'b1;
    go(10'h050, 10'd1, 10'd2, 4'b1111);
    checks++;
    if (overflow !== 1'b1 || bram_we !== 4'b0 || busy !== 1'b1 ||
        done !== 1'b0) begin
      errors++;
      $display("FAIL ovf_same got ovf=%b we=%b busy=%b done=%b exp 1/0000/1/0",
               overflow, bram_we, busy, done);
    end
    tick();
    checks++;
    if (bram_addr !== 10'h050 || done !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL ovf_cnt1 got addr=%h done=%b exp 050/0", bram_addr, done);
    end
    tick();
    in_data_available = 1'b0;
    checks++;
    if (bram_addr !== 10'h051 || done !== 1'b1) begin
      errors++;
      $display("FAIL ovf_cnt2 got addr=%h done=%b exp 051/1", bram_addr, done);
    end
  endtask

  task automatic test_zero_and_ignore();
    do_reset();
    go(10'h077, 10'd1, 10'd0, 4'b1111);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || bram_we !== 4'b0) begin
      errors++;
      $display("FAIL zero_rows got done=%b busy=%b we=%b exp 1/0/0000",
               done, busy, bram_we);
    end
    go(10'h020, 10'd1, 10'd2, 4'b0011);
    checks++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL done_fall got done=%b busy=%b exp 0/1", done, busy);
    end
    in_data = 32'h01020304;
    in_data_available = 1'b1;
    base_addr = 10'h100;
    num_rows = 10'd9;
    validity_mask = 4'b1111;
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (bram_addr !== 10'h020 || bram_wdata !== 32'h00000304 ||
        bram_we !== 4'b0011 || busy !== 1'b1) begin
      errors++;
      $display("FAIL ign_row0 got=%h/%h/%b exp=020/00000304/0011",
               bram_addr, bram_wdata, bram_we);
    end
    tick();
    in_data_available = 1'b0;
    checks++;
    if (bram_addr !== 10'h021 || done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL ign_row1 got addr=%h done=%b exp 021/1", bram_addr, done);
    end
  endtask

  task automatic test_reset_mid_run();
    logic [49:0] got;
    do_reset();
    go(10'h050, 10'd2, 10'd5, 4'b1111);
    in_data = 32'hFEEDFACE;
    in_data_available = 1'b1;
    tick();
    tick();
    checks++;
    if (bram_addr !== 10'h052 || bram_we !== 4'b1111) begin
      errors++;
      $display("FAIL rst_pre got addr=%h we=%b exp 052/1111", bram_addr, bram_we);
    end
    #2;
    resetn = 1'b0;
    #1;
    got = {bram_addr, bram_wdata, bram_we, busy, done, overflow};
    checks++;
    if (got !== 50'd0) begin
      errors++;
      $display("FAIL rst_async got=%h exp=0", got);
    end
    #2;
    resetn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (bram_we !== 4'b0 || busy !== 1'b0 || done !== 1'b0) begin
        errors++;
        $display("FAIL rst_after%0d got we=%b busy=%b done=%b exp 0",
                 i, bram_we, busy, done);
      end
    end
    in_data_available = 1'b0;
  endtask

  initial begin
    resetn = 1'b0;
    start = 1'b0;
    base_addr = '0;
    addr_stride = '0;
    num_rows = '0;
    validity_mask = '0;
    in_data = '0;
    in_data_available = 1'b0;
    #12;
    test_reset();
    resetn = 1'b1;
    tick();
    test_basic();
    test_mask_stride();
    test_gaps_wrap();
    test_overflow();
    test_zero_and_ignore();
    test_reset_mid_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
